// File: rtl/burst_demux_locking.sv
// -----------------------------------------------------------------------------
// burst_demux_locking
//
// Purpose:
//   Splits one valid/ready/last burst stream into NUM_DESTS output streams.
//   The first beat of every burst is a header whose low bits name the
//   destination. The route stays locked to that destination until the beat
//   carrying last=1 has been accepted. Bursts addressed to a nonexistent
//   destination are swallowed and counted. One registered stage sits between
//   the input and all outputs. It sustains one beat per cycle, and bursts leave
//   in the order they arrived.
//
// Parameters:
//   NUM_DESTS     number of output streams (>= 2)
//   DATA_WIDTH    payload width of every stream
//   STRIP_HEADER  1: header beat consumed; 0: header forwarded as first beat
//   DROP_CNT_W    width of the saturating dropped-burst counter
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst            asynchronous reset, active high
//   i_in_valid     input stream beat valid
//   o_in_ready     input stream ready (held low while rst is high)
//   i_in_last      input stream end-of-burst marker
//   i_in_data      input stream payload
//   o_out_valid    per-destination beat valid
//   i_out_ready    per-destination ready
//   o_out_last     per-destination end-of-burst marker
//   o_out_data     per-destination payload (zero on unselected destinations)
//   o_busy         high while mid-burst or while the output register is full
//   o_drop_count   saturating count of bursts dropped for a bad destination
// -----------------------------------------------------------------------------
module burst_demux_locking #(
    parameter int NUM_DESTS    = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int STRIP_HEADER = 1,
    parameter int DROP_CNT_W   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,

    input  logic                                  i_in_valid,
    output logic                                  o_in_ready,
    input  logic                                  i_in_last,
    input  logic [DATA_WIDTH-1:0]                 i_in_data,

    output logic [NUM_DESTS-1:0]                  o_out_valid,
    input  logic [NUM_DESTS-1:0]                  i_out_ready,
    output logic [NUM_DESTS-1:0]                  o_out_last,
    output logic [NUM_DESTS-1:0][DATA_WIDTH-1:0]  o_out_data,

    output logic                                  o_busy,
    output logic [DROP_CNT_W-1:0]                 o_drop_count
);

    localparam int DEST_W = $clog2(NUM_DESTS);

    // One extra bit so the limit still fits when NUM_DESTS is a power of two.
    localparam logic [DEST_W:0] DEST_LIMIT = (DEST_W+1)'(NUM_DESTS);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_FWD  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                  r_state;
    logic                    r_vld;
    logic [DEST_W-1:0]       r_dest;
    logic                    r_last;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DROP_CNT_W-1:0]   r_drop_cnt;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic [NUM_DESTS-1:0]    w_dest_sel;
    logic                    w_sel_ready;
    logic                    w_drain;
    logic                    w_accept;
    logic [DEST_W-1:0]       w_hdr_dest;
    logic                    w_hdr_ok;
    logic                    w_hdr_fwd;
    logic                    w_load;

    // One-hot decode of the locked destination, shared by the ready mux and
    // the output fan-out.
    // NOTE: every signal written in an always_comb gets a default before any
    // conditional assignment, so no path leaves it unassigned and no latch
    // is inferred.
    always_comb begin
        w_dest_sel = '0;
        for (int d = 0; d < NUM_DESTS; d++) begin
            if (r_dest == DEST_W'(d)) begin
                w_dest_sel[d] = 1'b1;
            end
        end
    end

    assign w_sel_ready = |(i_out_ready & w_dest_sel);
    assign w_drain     = r_vld & w_sel_ready;

    // In DROP the input is always ready because discarded beats never need
    // the output register. Any beat still held there drains independently.
    assign o_in_ready  = !rst & (!r_vld | w_drain | (r_state == S_DROP));
    assign w_accept    = i_in_valid & o_in_ready;

    // Only the low bits select the destination. Upper header bits are ignored.
    assign w_hdr_dest  = i_in_data[DEST_W-1:0];
    assign w_hdr_ok    = ({1'b0, w_hdr_dest} < DEST_LIMIT);

    // A header enters the output register only when it is kept and routable.
    assign w_hdr_fwd   = (STRIP_HEADER == 0) & w_hdr_ok;

    assign w_load      = w_accept &
                         (((r_state == S_HDR) & w_hdr_fwd) | (r_state == S_FWD));

    // -------------------------------------------------------------------------
    // FSM, output register and drop counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so that every
    // register samples the pre-edge value of every other register.
    // NOTE: the payload register is reset as well, because the outputs must
    // read zero while reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_HDR;
            r_vld      <= 1'b0;
            r_dest     <= '0;
            r_last     <= 1'b0;
            r_data     <= '0;
            r_drop_cnt <= '0;
        end else begin
            // Output register: a load wins over a drain, so a simultaneous
            // drain and load keeps r_vld high with the new beat.
            if (w_load) begin
                r_vld  <= 1'b1;
                r_last <= i_in_last;
                r_data <= i_in_data;
            end else if (w_drain) begin
                r_vld  <= 1'b0;
            end

            case (r_state)
                S_HDR: begin
                    if (w_accept) begin
                        if (w_hdr_ok) begin
                            // A header is accepted only when the register is
                            // empty or draining this cycle. Re-pointing r_dest
                            // therefore never retargets a beat still waiting.
                            r_dest  <= w_hdr_dest;
                            r_state <= i_in_last ? S_HDR : S_FWD;
                        end else begin
                            if (r_drop_cnt != '1) begin
                                r_drop_cnt <= r_drop_cnt + 1'b1;
                            end
                            r_state <= i_in_last ? S_HDR : S_DROP;
                        end
                    end
                end

                S_FWD: begin
                    if (w_accept && i_in_last) begin
                        r_state <= S_HDR;
                    end
                end

                S_DROP: begin
                    if (w_accept && i_in_last) begin
                        r_state <= S_HDR;
                    end
                end

                default: begin
                    r_state <= S_HDR;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output fan-out: only the locked destination sees the register contents
    // -------------------------------------------------------------------------
    always_comb begin
        o_out_valid = '0;
        o_out_last  = '0;
        o_out_data  = '0;
        for (int d = 0; d < NUM_DESTS; d++) begin
            if (w_dest_sel[d]) begin
                o_out_valid[d] = r_vld;
                o_out_last[d]  = r_last;
                o_out_data[d]  = r_data;
            end
        end
    end

    assign o_busy       = (r_state != S_HDR) | r_vld;
    assign o_drop_count = r_drop_cnt;

endmodule

// File: tb/tb_burst_demux_locking.sv
// -----------------------------------------------------------------------------
// tb_burst_demux_locking
//
// Two instances share the clock and reset:
//   u_a : NUM_DESTS=2, STRIP_HEADER=1, DROP_CNT_W=16
//   u_b : NUM_DESTS=3, STRIP_HEADER=0, DROP_CNT_W=2 (small counter so that
//         saturation is reachable in a few bursts)
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, before the next edge.
// -----------------------------------------------------------------------------
module tb_burst_demux_locking;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic             a_in_valid = 1'b0;
    logic             a_in_ready;
    logic             a_in_last  = 1'b0;
    logic [31:0]      a_in_data  = '0;
    logic [1:0]       a_out_valid;
    logic [1:0]       a_out_ready = 2'b11;
    logic [1:0]       a_out_last;
    logic [1:0][31:0] a_out_data;
    logic             a_busy;
    logic [15:0]      a_drop;

    // ---------------- instance B ----------------
    logic             b_in_valid = 1'b0;
    logic             b_in_ready;
    logic             b_in_last  = 1'b0;
    logic [31:0]      b_in_data  = '0;
    logic [2:0]       b_out_valid;
    logic [2:0]       b_out_ready = 3'b111;
    logic [2:0]       b_out_last;
    logic [2:0][31:0] b_out_data;
    logic             b_busy;
    logic [1:0]       b_drop;

    burst_demux_locking #(
        .NUM_DESTS(2), .DATA_WIDTH(32), .STRIP_HEADER(1), .DROP_CNT_W(16)
    ) u_a (
        .clk          (clk),
        .rst          (rst),
        .i_in_valid   (a_in_valid),
        .o_in_ready   (a_in_ready),
        .i_in_last    (a_in_last),
        .i_in_data    (a_in_data),
        .o_out_valid  (a_out_valid),
        .i_out_ready  (a_out_ready),
        .o_out_last   (a_out_last),
        .o_out_data   (a_out_data),
        .o_busy       (a_busy),
        .o_drop_count (a_drop)
    );

    burst_demux_locking #(
        .NUM_DESTS(3), .DATA_WIDTH(32), .STRIP_HEADER(0), .DROP_CNT_W(2)
    ) u_b (
        .clk          (clk),
        .rst          (rst),
        .i_in_valid   (b_in_valid),
        .o_in_ready   (b_in_ready),
        .i_in_last    (b_in_last),
        .i_in_data    (b_in_data),
        .o_out_valid  (b_out_valid),
        .i_out_ready  (b_out_ready),
        .o_out_last   (b_out_last),
        .o_out_data   (b_out_data),
        .o_busy       (b_busy),
        .o_drop_count (b_drop)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic l, input logic [31:0] d);
        a_in_valid = v;
        a_in_last  = l;
        a_in_data  = d;
    endtask

    task automatic b_drive(input logic v, input logic l, input logic [31:0] d);
        b_in_valid = v;
        b_in_last  = l;
        b_in_data  = d;
    endtask

    initial begin
        // ------------------------------------------------------------ reset
        tick();
        tick();
        check("rst_a_in_ready",  a_in_ready,  1'b0);
        check("rst_a_out_valid", a_out_valid, 2'b00);
        check("rst_a_out_last",  a_out_last,  2'b00);
        check("rst_a_out_data0", a_out_data[0], 32'h0);
        check("rst_a_out_data1", a_out_data[1], 32'h0);
        check("rst_a_busy",      a_busy,      1'b0);
        check("rst_a_drop",      a_drop,      16'h0);
        check("rst_b_out_valid", b_out_valid, 3'b000);
        check("rst_b_drop",      b_drop,      2'd0);
        rst = 1'b0;
        #1;
        check("post_rst_a_in_ready", a_in_ready, 1'b1);

        // ------------------------------------------ 1: hdr 1, A, B(last)
        a_drive(1'b1, 1'b0, 32'h0000_0001);
        tick();
        check("t1_hdr_stripped", a_out_valid, 2'b00);
        check("t1_busy_fwd",     a_busy,      1'b1);
        a_drive(1'b1, 1'b0, 32'hAAAA_0001);
        tick();
        check("t1_A_valid", a_out_valid,   2'b10);
        check("t1_A_data",  a_out_data[1], 32'hAAAA_0001);
        check("t1_A_last",  a_out_last,    2'b00);
        check("t1_A_other", a_out_data[0], 32'h0);
        a_drive(1'b1, 1'b1, 32'hAAAA_0002);
        tick();
        check("t1_B_valid", a_out_valid,   2'b10);
        check("t1_B_data",  a_out_data[1], 32'hAAAA_0002);
        check("t1_B_last",  a_out_last,    2'b10);
        a_drive(1'b0, 1'b0, 32'h0);
        tick();
        check("t1_idle_valid", a_out_valid, 2'b00);
        check("t1_idle_busy",  a_busy,      1'b0);

        // ------------------------- 2: hdr0,{X,Y last},hdr1,{Z last}
        a_drive(1'b1, 1'b0, 32'h0000_0100);  // dest 0, upper bits ignored
        tick();
        check("t2_hdr0_stripped", a_out_valid, 2'b00);
        a_drive(1'b1, 1'b0, 32'h1111_0000);
        tick();
        check("t2_X_valid", a_out_valid,   2'b01);
        check("t2_X_data",  a_out_data[0], 32'h1111_0000);
        a_drive(1'b1, 1'b1, 32'h2222_0000);
        tick();
        check("t2_Y_data",  a_out_data[0], 32'h2222_0000);
        check("t2_Y_last",  a_out_last,    2'b01);
        a_drive(1'b1, 1'b0, 32'hF0F0_0003);  // dest 1
        check("t2_hdr1_ready_while_Y_held", a_in_ready, 1'b1);
        tick();
        check("t2_hdr1_stripped", a_out_valid, 2'b00);
        a_drive(1'b1, 1'b1, 32'h3333_0000);
        tick();
        check("t2_Z_valid", a_out_valid,   2'b10);
        check("t2_Z_data",  a_out_data[1], 32'h3333_0000);
        check("t2_Z_last",  a_out_last,    2'b10);
        a_drive(1'b0, 1'b0, 32'h0);
        tick();
        check("t2_idle_valid", a_out_valid, 2'b00);

        // ------------------------------- 3: back-pressure on out[0]
        a_drive(1'b1, 1'b0, 32'h0000_0000);
        tick();
        a_drive(1'b1, 1'b0, 32'h5555_0001);
        tick();
        check("t3_P1_data", a_out_data[0], 32'h5555_0001);
        a_out_ready = 2'b10;
        a_drive(1'b1, 1'b0, 32'h5555_0002);
        #1;
        check("t3_stall_in_ready", a_in_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stall_valid", a_out_valid,   2'b01);
            check("t3_stall_data",  a_out_data[0], 32'h5555_0001);
            check("t3_stall_ready", a_in_ready,    1'b0);
        end
        a_out_ready = 2'b11;
        #1;
        check("t3_resume_in_ready", a_in_ready, 1'b1);
        tick();
        check("t3_P2_valid", a_out_valid,   2'b01);
        check("t3_P2_data",  a_out_data[0], 32'h5555_0002);
        a_drive(1'b1, 1'b1, 32'h5555_0003);
        tick();
        check("t3_P3_data", a_out_data[0], 32'h5555_0003);
        check("t3_P3_last", a_out_last,    2'b01);
        a_drive(1'b0, 1'b0, 32'h0);
        tick();
        check("t3_no_dup", a_out_valid, 2'b00);

        // ----------------------- 4: bad dest on B (NUM_DESTS=3), drop
        b_drive(1'b1, 1'b0, 32'h0000_0003);
        #1;
        check("t4_hdr_ready", b_in_ready, 1'b1);
        tick();
        check("t4_hdr_drop_cnt", b_drop,      2'd1);
        check("t4_hdr_no_out",   b_out_valid, 3'b000);
        check("t4_busy_drop",    b_busy,      1'b1);
        for (int i = 0; i < 4; i++) begin
            b_drive(1'b1, (i == 3), 32'hDEAD_0000 + 32'(i));
            #1;
            check("t4_drop_ready", b_in_ready, 1'b1);
            tick();
            check("t4_drop_no_out", b_out_valid, 3'b000);
        end
        check("t4_drop_done_busy", b_busy, 1'b0);
        check("t4_drop_cnt_1",     b_drop, 2'd1);
        b_drive(1'b1, 1'b1, 32'h0000_0007);  // low bits 3: bad, single beat
        tick();
        check("t4_cnt_2", b_drop, 2'd2);
        tick();
        check("t4_cnt_3", b_drop, 2'd3);
        tick();
        check("t4_cnt_sat", b_drop, 2'd3);
        check("t4_sat_no_out", b_out_valid, 3'b000);

        // ------------------------ 5: header-only burst, STRIP=0 vs 1
        b_drive(1'b1, 1'b1, 32'h0000_00C0);  // dest 0, last=1
        tick();
        check("t5_b_hdr_valid", b_out_valid,   3'b001);
        check("t5_b_hdr_data",  b_out_data[0], 32'h0000_00C0);
        check("t5_b_hdr_last",  b_out_last,    3'b001);
        b_drive(1'b1, 1'b0, 32'h0000_0002);  // dest 2, header kept
        tick();
        check("t5_b_d2_hdr_valid", b_out_valid,   3'b100);
        check("t5_b_d2_hdr_data",  b_out_data[2], 32'h0000_0002);
        b_drive(1'b1, 1'b1, 32'h7777_0000);
        tick();
        check("t5_b_d2_body_data", b_out_data[2], 32'h7777_0000);
        check("t5_b_d2_body_last", b_out_last,    3'b100);
        b_drive(1'b0, 1'b0, 32'h0);
        tick();
        check("t5_b_idle", b_out_valid, 3'b000);
        check("t5_b_busy", b_busy,      1'b0);
        a_drive(1'b1, 1'b1, 32'h0000_0001);
        tick();
        check("t5_a_vanish_valid", a_out_valid, 2'b00);
        check("t5_a_vanish_busy",  a_busy,      1'b0);
        check("t5_a_drop_zero",    a_drop,      16'h0);

        // ------------------------------------- 6: reset mid-burst
        a_drive(1'b1, 1'b0, 32'h0000_0000);
        tick();
        a_drive(1'b1, 1'b0, 32'h9999_0001);
        tick();
        check("t6_pre_rst_valid", a_out_valid, 2'b01);
        rst = 1'b1;
        #1;
        check("t6_rst_valid",    a_out_valid, 2'b00);
        check("t6_rst_in_ready", a_in_ready,  1'b0);
        check("t6_rst_busy",     a_busy,      1'b0);
        check("t6_rst_b_drop",   b_drop,      2'd0);
        tick();
        rst = 1'b0;
        a_drive(1'b1, 1'b0, 32'h0000_0001);  // must decode as header, dest 1
        tick();
        check("t6_hdr_after_rst", a_out_valid, 2'b00);
        a_drive(1'b1, 1'b1, 32'h9999_0002);
        tick();
        check("t6_R_valid", a_out_valid,   2'b10);
        check("t6_R_data",  a_out_data[1], 32'h9999_0002);
        a_drive(1'b0, 1'b0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time bound so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule
